sha256_avalon_master: RTL and testbench
=======================================

Name: sha256_avalon_master

Overview:
- Avalon-MM style host-side initiator that drives the SHA-256 `wrapper` slave through its 5-bit word-addressed register file.
- Accepts one pre-padded 512-bit block on a start pulse.
- Sequence: writes message words to addresses 0-15, writes 1 to start register 24, waits a fixed compute time, reads digest addresses 16-23.
- Presents the 256-bit digest with a done pulse; sits between a block source (CPU shim / DMA) and the hash slave.

Parameters:
- WAIT_CYCLES, 70, idle cycles between start write and first digest read; minimum 1.
- READ_LATENCY, 1, cycles from read issue to valid iData; legal 0-3.

Ports:
- iClk  in  1  system clock, rising edge
- iReset  in  1  asynchronous, active-high reset
- iStart  in  1  one-cycle request; sampled only in IDLE
- iBlock  in  512  padded block; W0 in [511:480], W15 in [31:0]
- oBusy  out  1  high from accepted start until oDone cycle inclusive
- oDone  out  1  one-cycle pulse when digest complete
- oDigest  out  256  H0 in [255:224] ... H7 in [31:0]
- oChipSelect_n  out  1  low only during bus cycles
- oWrite_n  out  1  low during write cycles
- oRead_n  out  1  low during read-issue cycles
- oAddress  out  5  slave word address
- oData  out  32  write data
- iData  in  32  read data from slave

Behaviour:
- Reset values: oBusy=0, oDone=0, oDigest=0, oChipSelect_n=1, oWrite_n=1, oRead_n=1, oAddress=0, oData=0; state IDLE; counters cleared.
- Reset mid-operation: bus released on the same edge, digest cleared, no oDone.
- All bus outputs are registered.
- oWrite_n and oRead_n are never both low. oChipSelect_n=1 whenever both are high.
- FSM IDLE -> WRITE -> START -> WAIT -> READ -> DONE -> IDLE.
- IDLE:
  - iStart=1 latches iBlock into a 512-bit holding register, sets oBusy, goes to WRITE.
  - iStart while not in IDLE is ignored (no queueing).
- WRITE: 16 cycles, k=0..15.
  - oAddress=k, oData=block[32k+31:32k].
  - Address 0 carries W15, the length word; address 15 carries W0.
- START: one cycle, oAddress=24, oData=1.
- WAIT:
  - Bus idle for exactly WAIT_CYCLES cycles.
  - Counter width is clog2(WAIT_CYCLES+1).
- READ: 8 issue cycles, oRead_n=0, oAddress=16+j for j=0..7.
  - iData sampled READ_LATENCY cycles after each issue cycle (0 = same cycle) into oDigest[32j+31:32j].
  - Capture index is tracked by a separate counter or shift pipe.
  - Bus idles during the READ_LATENCY drain cycles; FSM leaves READ only after the 8th capture.
- DONE: oDone=1 for one cycle, oBusy stays 1 this cycle; then IDLE with oBusy=0.
- oDigest holds its value until overwritten word-by-word by the next operation.
- Timing, edge 0 = iStart sampled:
  - Writes in cycles 1-16, start write in cycle 17.
  - Reads issued in cycles 18+W .. 25+W.
  - oDone high in cycle 26+W+L (W=WAIT_CYCLES, L=READ_LATENCY).
  - Defaults: cycle 97.
- A new iStart is accepted in the IDLE cycle immediately after DONE; no dead cycle required.

Optional Feature:
- Macro: SHA_MASTER_BYTESWAP_EN.
- Defined:
  - Every 32-bit word is byte-reversed on both paths: oData on writes, iData on captures.
  - For little-endian hosts: block word 0x80636261 is written as 0x61626380.
- Undefined: words pass unchanged.
- Reset values, ordering and timing are identical either way.

Test Plan:
- Bench: behavioural slave model with 32-entry register array, start bit, and digest preloaded into 16-23 after WAIT; READ_LATENCY=1.
- "abc" block (W0=0x61626380, W15=0x00000018, others 0), single iStart -> address 0 gets 0x18, address 15 gets 0x61626380, address 24 gets 1; oDone at cycle 97; oDigest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- iStart pulsed in cycles 5 and 40 of an active operation -> ignored: exactly 16+1 writes and 8 reads, one oDone.
- iReset asserted during WAIT cycle 30 -> all bus outputs idle immediately, oBusy=0, oDigest=0, no oDone; next iStart completes normally.
- READ_LATENCY=3, WAIT_CYCLES=5 -> slave returns 0x11111111*(j+1) per read; oDigest word j matches; oDone at cycle 34.
- Back-to-back: iStart in the cycle after oDone -> second run accepted, oDigest replaced, two oDone pulses 98 cycles apart.
- SHA_MASTER_BYTESWAP_EN defined, block word 0x80636261 at W0 -> address 15 written as 0x61626380; read 0xba7816bf captured as 0xbf1678ba.

Source files
------------

// File: rtl/sha256_avalon_master.sv
// Avalon-MM initiator: writes one 512-bit block to the SHA-256 slave and reads back the digest.
// Define SHA_MASTER_BYTESWAP_EN to byte-reverse every bus word in both directions.
module sha256_avalon_master #(
    parameter int WAIT_CYCLES  = 70,
    parameter int READ_LATENCY = 1
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic         iStart,
    input  logic [511:0] iBlock,
    output logic         oBusy,
    output logic         oDone,
    output logic [255:0] oDigest,
    output logic         oChipSelect_n,
    output logic         oWrite_n,
    output logic         oRead_n,
    output logic [4:0]   oAddress,
    output logic [31:0]  oData,
    input  logic [31:0]  iData
);

    localparam int          WW  = $clog2(WAIT_CYCLES + 1);
    localparam logic [3:0]  SEL = 4'b0001 << READ_LATENCY;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        START,
        WAIT,
        READ,
        DONE
    } state_t;

    state_t         state;
    logic [511:0]   blk;
    logic [3:0]     wr_idx;
    logic [3:0]     wr_nxt;
    logic [WW-1:0]  wait_cnt;
    logic [2:0]     rd_idx;
    logic [2:0]     rd_nxt;
    logic [2:0]     cap_idx;
    logic [2:0]     pipe;
    logic [3:0]     taps;
    logic           cap;

    function automatic logic [31:0] swap(input logic [31:0] w);
`ifdef SHA_MASTER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    assign wr_nxt = wr_idx + 4'd1;
    assign rd_nxt = rd_idx + 3'd1;
    // Tap 0 is the live issue strobe, tap N is the issue from N cycles ago.
    assign taps   = {pipe, ~oRead_n};
    assign cap    = |(taps & SEL);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state         <= IDLE;
            blk           <= '0;
            wr_idx        <= '0;
            wait_cnt      <= '0;
            rd_idx        <= '0;
            cap_idx       <= '0;
            pipe          <= '0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
            oDigest       <= '0;
            oChipSelect_n <= 1'b1;
            oWrite_n      <= 1'b1;
            oRead_n       <= 1'b1;
            oAddress      <= '0;
            oData         <= '0;
        end else begin
            oDone <= 1'b0;
            pipe  <= {pipe[1:0], ~oRead_n};
            if (cap) begin
                oDigest[{cap_idx, 5'd0} +: 32] <= swap(iData);
                cap_idx                        <= cap_idx + 3'd1;
            end
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        blk           <= iBlock;
                        oBusy         <= 1'b1;
                        oChipSelect_n <= 1'b0;
                        oWrite_n      <= 1'b0;
                        oAddress      <= 5'd0;
                        oData         <= swap(iBlock[31:0]);
                        wr_idx        <= 4'd0;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_idx == 4'd15) begin
                        oAddress <= 5'd24;
                        oData    <= 32'd1;
                        state    <= START;
                    end else begin
                        wr_idx   <= wr_nxt;
                        oAddress <= {1'b0, wr_nxt};
                        oData    <= swap(blk[{wr_nxt, 5'd0} +: 32]);
                    end
                end
                START: begin
                    oChipSelect_n <= 1'b1;
                    oWrite_n      <= 1'b1;
                    oAddress      <= 5'd0;
                    oData         <= 32'd0;
                    wait_cnt      <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WW'(WAIT_CYCLES - 1)) begin
                        oChipSelect_n <= 1'b0;
                        oRead_n       <= 1'b0;
                        oAddress      <= 5'd16;
                        rd_idx        <= 3'd0;
                        cap_idx       <= 3'd0;
                        state         <= READ;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (!oRead_n) begin
                        if (rd_idx == 3'd7) begin
                            oChipSelect_n <= 1'b1;
                            oRead_n       <= 1'b1;
                            oAddress      <= 5'd0;
                        end else begin
                            rd_idx   <= rd_nxt;
                            oAddress <= {2'b10, rd_nxt};
                        end
                    end
                    if (cap && cap_idx == 3'd7) begin
                        oDone <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_avalon_master.sv
// Directed bench: behavioural register-file slaves for a default master and a W=5/L=3 master.
module tb_sha256_avalon_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start1, busy1, done1, cs1, wr1n, rd1n;
    logic [511:0] block1;
    logic [255:0] dig1;
    logic [4:0]   addr1;
    logic [31:0]  wdata1, rdata1;

    logic         start2, busy2, done2, cs2, wr2n, rd2n;
    logic [511:0] block2;
    logic [255:0] dig2;
    logic [4:0]   addr2;
    logic [31:0]  wdata2, rdata2;

    sha256_avalon_master dut (
        .iClk(clk), .iReset(rst), .iStart(start1), .iBlock(block1),
        .oBusy(busy1), .oDone(done1), .oDigest(dig1),
        .oChipSelect_n(cs1), .oWrite_n(wr1n), .oRead_n(rd1n),
        .oAddress(addr1), .oData(wdata1), .iData(rdata1)
    );

    sha256_avalon_master #(.WAIT_CYCLES(5), .READ_LATENCY(3)) dut2 (
        .iClk(clk), .iReset(rst), .iStart(start2), .iBlock(block2),
        .oBusy(busy2), .oDone(done2), .oDigest(dig2),
        .oChipSelect_n(cs2), .oWrite_n(wr2n), .oRead_n(rd2n),
        .oAddress(addr2), .oData(wdata2), .iData(rdata2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wrc1 = 0, rdc1 = 0, dnc1 = 0, viol1 = 0;
    int wrc2 = 0, rdc2 = 0, dnc2 = 0, viol2 = 0;
    logic tbl_b = 1'b0;
    logic [31:0] regs1 [32];
    logic [31:0] regs2 [32];
    logic [31:0] p1, q2a, q2b, q2c;

    assign rdata1 = p1;
    assign rdata2 = q2c;

    function automatic logic [31:0] bs(input logic [31:0] w);
`ifdef SHA_MASTER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [255:0] bsd(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = bs(d[32*i +: 32]);
        return r;
    endfunction

    // Slave 1 digest: table A holds the "abc" hash with H7 at address 16.
    function automatic logic [31:0] rd_val1(input logic [4:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (tbl_b) v = 32'hC0DE0000 + 32'(a);
        else begin
            case (a)
                5'd16: v = 32'hf20015ad;
                5'd17: v = 32'hb410ff61;
                5'd18: v = 32'h96177a9c;
                5'd19: v = 32'hb00361a3;
                5'd20: v = 32'h5dae2223;
                5'd21: v = 32'h414140de;
                5'd22: v = 32'h8f01cfea;
                5'd23: v = 32'hba7816bf;
                default: v = regs1[a];
            endcase
        end
        return v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!cs1 && !wr1n) begin
            regs1[addr1] <= wdata1;
            wrc1 <= wrc1 + 1;
        end
        if (!cs1 && !rd1n) rdc1 <= rdc1 + 1;
        p1 <= (!cs1 && !rd1n) ? rd_val1(addr1) : 32'hDEADDEAD;
        if (done1) dnc1 <= dnc1 + 1;
        if ((cs1 !== (wr1n & rd1n)) || (!wr1n && !rd1n)) viol1 <= viol1 + 1;

        if (!cs2 && !wr2n) begin
            regs2[addr2] <= wdata2;
            wrc2 <= wrc2 + 1;
        end
        if (!cs2 && !rd2n) rdc2 <= rdc2 + 1;
        q2a <= (!cs2 && !rd2n && addr2 >= 5'd16) ?
               32'h11111111 * (32'(addr2) - 32'd15) : 32'hDEADDEAD;
        q2b <= q2a;
        q2c <= q2b;
        if (done2) dnc2 <= dnc2 + 1;
        if ((cs2 !== (wr2n & rd2n)) || (!wr2n && !rd2n)) viol2 <= viol2 + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done1(input int limit);
        for (int i = 0; i < limit && done1 !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic wait_done2(input int limit);
        for (int i = 0; i < limit && done2 !== 1'b1; i++) @(negedge clk);
    endtask

    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK2 = {32'hdeadbeef, 448'h0, 32'h00000100};
    localparam logic [511:0] BLK4 = {32'h80636261, 448'h0, 32'h00000018};
    localparam logic [255:0] DIG_A = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_B = 256'hc0de0017_c0de0016_c0de0015_c0de0014_c0de0013_c0de0012_c0de0011_c0de0010;
    localparam logic [255:0] DIG_2 = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

    int t0, c1, wr0, rd0, dn0;

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        block1 = '0;
        block2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_digest", dig1, 0);
        check("rst_cs_n", cs1, 1);
        check("rst_write_n", wr1n, 1);
        check("rst_read_n", rd1n, 1);
        check("rst_addr", addr1, 0);
        check("rst_data", wdata1, 0);
        check("rst_cs_n_2", cs2, 1);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: abc block, with stray starts at cycles 5 and 40
        block1 = ABC;
        start1 = 1'b1;
        t0 = cyc;
        wr0 = wrc1;
        rd0 = rdc1;
        dn0 = dnc1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        start1 = 1'b1;
        block1 = '1;
        @(negedge clk);
        start1 = 1'b0;
        check("busy_active", busy1, 1);
        repeat (33) @(negedge clk);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(200);
        check("run1_done_seen", done1, 1);
        check("run1_done_cycle", cyc - t0, 97);
        check("run1_busy_in_done", busy1, 1);
        check("run1_writes", wrc1 - wr0, 17);
        check("run1_reads", rdc1 - rd0, 8);
        check("run1_addr0", regs1[0], bs(32'h00000018));
        check("run1_addr15", regs1[15], bs(32'h61626380));
        check("run1_addr24", regs1[24], 32'd1);
        check("run1_digest", dig1, bsd(DIG_A));
        c1 = cyc;

        // Run 2: back-to-back start in the first IDLE cycle
        tbl_b = 1'b1;
        block1 = BLK2;
        @(negedge clk);
        check("run1_done_pulse", done1, 0);
        check("run1_busy_clear", busy1, 0);
        check("run1_done_count", dnc1 - dn0, 1);
        start1 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(200);
        check("run2_done_seen", done1, 1);
        check("run2_done_cycle", cyc - t0, 97);
        check("run2_done_spacing", cyc - c1, 98);
        check("run2_addr0", regs1[0], bs(32'h00000100));
        check("run2_addr15", regs1[15], bs(32'hdeadbeef));
        check("run2_digest", dig1, bsd(DIG_B));

        // Run 3: reset during WAIT cycle 30
        @(negedge clk);
        tbl_b = 1'b0;
        block1 = ABC;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (29) @(negedge clk);
        check("run3_busy_pre", busy1, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_cs_n", cs1, 1);
        check("mid_rst_write_n", wr1n, 1);
        check("mid_rst_read_n", rd1n, 1);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_digest", dig1, 0);
        check("mid_rst_done", done1, 0);
        dn0 = dnc1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_rst_no_done", dnc1 - dn0, 0);

        // Run 4: normal run after reset, byte-order vector in W0
        block1 = BLK4;
        start1 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(200);
        check("run4_done_cycle", cyc - t0, 97);
        check("run4_addr15", regs1[15], bs(32'h80636261));
        check("run4_digest", dig1, bsd(DIG_A));

        // Second instance: WAIT_CYCLES=5, READ_LATENCY=3
        @(negedge clk);
        block2 = ABC;
        start2 = 1'b1;
        t0 = cyc;
        wr0 = wrc2;
        rd0 = rdc2;
        @(negedge clk);
        start2 = 1'b0;
        wait_done2(100);
        check("lat3_done_seen", done2, 1);
        check("lat3_done_cycle", cyc - t0, 34);
        check("lat3_digest", dig2, DIG_2);
        check("lat3_writes", wrc2 - wr0, 17);
        check("lat3_reads", rdc2 - rd0, 8);
        check("lat3_addr15", regs2[15], bs(32'h61626380));

        @(negedge clk);
        check("bus_protocol_1", viol1, 0);
        check("bus_protocol_2", viol2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
